// File: rtl/sys_array_pkg.sv
// Shared types for the systolic-array lock arbiters.
// State encoding for lock_arbiter (IDLE/GRANT/RELEASE).
package sys_array_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } lock_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req at or after rr_ptr,
// wrapping modulo N.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] pos;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        // Walk from farthest to nearest so the nearest hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            pos = IW'((int'(rr_ptr) + k) % N);
            if (req[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/lock_arbiter.sv
// Round-robin lock arbiter for a shared resource (IDLE/GRANT/RELEASE).
// Define LOCK_ARB_TIMEOUT_EN to enable the GRANT watchdog and timeout_err.
module lock_arbiter
    import sys_array_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int PAYLOAD_W = 96,
    parameter int TIMEOUT   = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*PAYLOAD_W-1:0] payload,
    output logic [NREQ-1:0]           grant,
    output logic                      start,
    output logic [PAYLOAD_W-1:0]      sel_payload,
    output logic [$clog2(NREQ)-1:0]   sel_id,
    input  logic                      finished,
    output logic [NREQ-1:0]           done,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IW = $clog2(NREQ);

    lock_state_t          state, state_nxt;
    logic [IW-1:0]        rr_ptr, rr_nxt;
    logic [NREQ-1:0]      grant_nxt, done_nxt;
    logic                 start_nxt;
    logic [IW-1:0]        id_nxt;
    logic [PAYLOAD_W-1:0] pl_nxt;
    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic                 expire;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

`ifdef LOCK_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;
    logic          err;

    assign expire = (state == GRANT) && (cnt == CW'(TIMEOUT - 1));

    // Counter idles at zero outside GRANT, so it starts clean on entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (state != GRANT) cnt <= '0;
            else                cnt <= cnt + 1'b1;
            if (expire && !finished) err <= 1'b1;
        end
    end

    assign timeout_err = err;
`else
    wire unused_timeout = (TIMEOUT > 0);

    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        grant_nxt = grant;
        start_nxt = 1'b0;
        done_nxt  = '0;
        id_nxt    = sel_id;
        pl_nxt    = sel_payload;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = GRANT;
                    start_nxt = 1'b1;
                    id_nxt    = pick_idx;
                    grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick_idx == IW'(i))
                            pl_nxt = payload[i*PAYLOAD_W +: PAYLOAD_W];
                    end
                end
            end
            GRANT: begin
                if (finished || expire) begin
                    state_nxt = RELEASE;
                    grant_nxt = '0;
                    done_nxt  = grant;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
                rr_nxt    = (sel_id == IW'(NREQ - 1)) ? '0 : sel_id + 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            start       <= 1'b0;
            done        <= '0;
            sel_id      <= '0;
            sel_payload <= '0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_nxt;
            grant       <= grant_nxt;
            start       <= start_nxt;
            done        <= done_nxt;
            sel_id      <= id_nxt;
            sel_payload <= pl_nxt;
        end
    end

endmodule

// File: tb/tb_lock_arbiter.sv
// Self-checking bench for lock_arbiter: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_lock_arbiter;

    localparam int N = 3;
    localparam int W = 96;
    localparam int T = 16;
`ifdef LOCK_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   payload = '0;
    logic             finished = 1'b0;
    logic [N-1:0]     grant;
    logic             start;
    logic [W-1:0]     sel_payload;
    logic [1:0]       sel_id;
    logic [N-1:0]     done;
    logic             busy;
    logic             timeout_err;

    always #5 clock = ~clock;

    lock_arbiter #(
        .NREQ      (N),
        .PAYLOAD_W (W),
        .TIMEOUT   (T)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .payload     (payload),
        .grant       (grant),
        .start       (start),
        .sel_payload (sel_payload),
        .sel_id      (sel_id),
        .finished    (finished),
        .done        (done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 = free, 1 = owned, 2 = releasing.
    int           m_phase;
    int           m_owner;
    int           m_ptr;
    int           m_age;
    bit           m_err;
    logic [W-1:0] m_pl;

    function automatic void model_reset();
        m_phase = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_age   = 0;
        m_err   = 1'b0;
        m_pl    = '0;
    endfunction

    function automatic void model_edge();
        bit found;
        if (!reset) begin
            model_reset();
            return;
        end
        case (m_phase)
            0: if (req != 0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (!found && req[j]) begin
                        found   = 1'b1;
                        m_owner = j;
                    end
                end
                m_pl    = payload[m_owner*W +: W];
                m_phase = 1;
                m_age   = 0;
            end
            1: begin
                if (finished) begin
                    m_phase = 2;
                end else if (TO_EN && m_age == T - 1) begin
                    m_phase = 2;
                    m_err   = 1'b1;
                end else begin
                    m_age++;
                end
            end
            default: begin
                m_ptr   = (m_owner + 1) % N;
                m_phase = 0;
            end
        endcase
    endfunction

    task automatic check_outs();
        check("grant", grant, (m_phase == 1) ? (1 << m_owner) : 0);
        check("start", start, (m_phase == 1 && m_age == 0));
        check("done", done, (m_phase == 2) ? (1 << m_owner) : 0);
        check("busy", busy, (m_phase != 0));
        check("sel_id", sel_id, m_owner);
        check("sel_payload", sel_payload, m_pl);
        check("timeout_err", timeout_err, m_err);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++)
            payload[i*W +: W] = {$urandom, $urandom, $urandom};
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic drain();
        req = '0;
        for (int i = 0; i < 10; i++) begin
            finished = (m_phase == 1);
            step();
        end
        finished = 1'b0;
    endtask

    logic [W-1:0] x;
    int           owners[$];
    int           exp_order[4] = '{0, 1, 2, 0};
    int           done_at;

    initial begin
        model_reset();
        rand_payload();
        // Reset state
        step();
        step();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;

        // Single requester
        x = {$urandom, $urandom, $urandom};
        payload[1*W +: W] = x;
        req = 3'b010;
        step();
        check("single_grant", grant, 3'b010);
        check("single_start", start, 1);
        check("single_payload", sel_payload, x);
        rand_payload();
        step();
        check("single_start_once", start, 0);
        check("single_hold", sel_payload, x);
        finished = 1'b1;
        step();
        finished = 1'b0;
        check("single_done", done, 3'b010);
        check("single_drop", grant, 0);
        req = '0;
        step();
        check("single_done_once", done, 0);
        drain();

        // Fairness from rr_ptr=0
        do_reset();
        req = 3'b111;
        for (int c = 0; c < 40; c++) begin
            finished = (m_phase == 1 && m_age == 3);
            step();
            if (start) owners.push_back(int'(sel_id));
        end
        finished = 1'b0;
        check("fair_count", (owners.size() >= 4), 1);
        for (int i = 0; i < 4 && i < owners.size(); i++)
            check("fair_order", owners[i], exp_order[i]);
        drain();

        // Wrap: rr_ptr=2 with req=011
        do_reset();
        req = 3'b010;
        step();
        req = 3'b011;
        finished = 1'b1;
        step();
        finished = 1'b0;
        step();
        step();
        check("wrap_first", sel_id, 0);
        check("wrap_first_start", start, 1);
        finished = 1'b1;
        step();
        finished = 1'b0;
        step();
        step();
        check("wrap_second", sel_id, 1);
        drain();

        // Spurious finished in IDLE
        req = '0;
        finished = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("spur_done", done, 0);
            check("spur_busy", busy, 0);
        end
        finished = 1'b0;

        // Reset mid-GRANT
        do_reset();
        req = 3'b100;
        step();
        check("rmg_pre", grant, 3'b100);
        #2;
        reset = 1'b0;
        #1;
        check("rmg_grant", grant, 0);
        check("rmg_done", done, 0);
        model_reset();
        step();
        reset = 1'b1;
        req = 3'b111;
        step();
        check("rmg_next", sel_id, 0);
        check("rmg_next_grant", grant, 3'b001);
        drain();

        // Watchdog
        do_reset();
        req = 3'b001;
        done_at = -1;
        step();
        for (int c = 1; c <= 100; c++) begin
            step();
            if (done != 0 && done_at < 0) done_at = c;
            if (!TO_EN && c == 100) begin
                check("wd_off_hold", grant, 3'b001);
                check("wd_off_err", timeout_err, 0);
            end
        end
        if (TO_EN) begin
            check("wd_done_at", done_at, 16);
            check("wd_err", timeout_err, 1);
        end
        drain();

        // Random traffic
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 9) < 3) req = N'($urandom_range(0, 7));
            finished = ($urandom_range(0, 4) == 0);
            rand_payload();
            if ($urandom_range(0, 499) == 0) do_reset();
            else step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
